div64x32: RTL and testbench

// - Sequential unsigned 64/32 divider: the inverse datapath of the mult32x32 multiplier.
// - Same start/busy handshake as mult32x32, so calculator control drives both identically.
// - Restoring division, one quotient bit per clock; returns 32-bit quotient and remainder.
// - Flags divide-by-zero and quotient overflow.

---
 rtl/div64x32_if.sv | 31 +++
 rtl/div64x32.sv | 113 +++++++++++
 tb/tb_div64x32.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/div64x32_if.sv
// Handshake and result bundle for the div64x32 sequential divider.
// DIV_DONE_PULSE_EN adds the one-cycle done completion pulse.
interface div64x32_if;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;
`ifdef DIV_DONE_PULSE_EN
    logic        done;
`endif

    modport master (
        output start, dividend, divisor,
`ifdef DIV_DONE_PULSE_EN
        input  done,
`endif
        input  busy, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef DIV_DONE_PULSE_EN
        output done,
`endif
        output busy, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div64x32.sv
// Sequential unsigned 64/32 restoring divider, one quotient bit per clock.
// Optional DIV_DONE_PULSE_EN adds a one-cycle done pulse on completion.
module div64x32 (
    input  logic      clk,
    input  logic      reset,
    div64x32_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] rem;
    logic [31:0] lo;
    logic [31:0] dvsr;
    logic [4:0]  cnt;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic        dbz_r;
    logic        ovf_r;

    logic [32:0] t;
    logic        qbit;
    logic [31:0] rem_nxt;
    logic [31:0] lo_nxt;
    logic        last;

    // A restored remainder is always < divisor, so the difference fits in
    // 32 bits even when t itself needs bit 32.
    always_comb begin
        t       = {rem, lo[31]};
        qbit    = (t >= {1'b0, dvsr});
        rem_nxt = qbit ? (t[31:0] - dvsr) : t[31:0];
        lo_nxt  = {lo[30:0], qbit};
        last    = (cnt == 5'd31);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0)                        state_nxt = ERR;
                    else if (bus.dividend[63:32] >= bus.divisor) state_nxt = ERR;
                    else                                          state_nxt = RUN;
                end
            end
            RUN:     if (last) state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem   <= '0;
            lo    <= '0;
            dvsr  <= '0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvsr  <= bus.divisor;
                        rem   <= bus.dividend[63:32];
                        lo    <= bus.dividend[31:0];
                        cnt   <= '0;
                        dbz_r <= (bus.divisor == '0);
                        ovf_r <= (bus.divisor != '0) && (bus.dividend[63:32] >= bus.divisor);
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        quo_r <= lo_nxt;
                        rem_r <= rem_nxt;
                    end
                end
                ERR: begin
                    quo_r <= '1;
                    rem_r <= lo;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_DONE_PULSE_EN
    logic done_r;

    always_ff @(posedge clk) begin
        if (reset) done_r <= 1'b0;
        else       done_r <= (state == ERR) || ((state == RUN) && last);
    end

    assign bus.done = done_r;
`endif

    assign bus.busy        = (state != IDLE);
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_div64x32.sv
// Directed self-checking bench for div64x32 (hand-computed expectations).
// Also checks the done pulse when built with DIV_DONE_PULSE_EN.
module tb_div64x32;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div64x32_if bus ();

    div64x32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input int cyc, input int cyc_exp,
                             input logic [31:0] q, input logic [31:0] r,
                             input logic dbz, input logic ovf);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'(cyc_exp));
        check({tag, "_quotient"},    64'(bus.quotient), 64'(q));
        check({tag, "_remainder"},   64'(bus.remainder), 64'(r));
        check({tag, "_dbz"},         64'(bus.div_by_zero), 64'(dbz));
        check({tag, "_ovf"},         64'(bus.overflow), 64'(ovf));
    endtask

    // Start one operation and count cycles busy stays high (bounded).
    task automatic run_op(input logic [63:0] dd, input logic [31:0] dv, output int cyc);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
`ifdef DIV_DONE_PULSE_EN
        check("done_pulse_hi", 64'(bus.done), 64'd1);
        @(negedge clk);
        check("done_pulse_lo", 64'(bus.done), 64'd0);
`endif
    endtask

    logic [63:0] big;
    int          cyc;

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_quotient",  64'(bus.quotient), 64'd0);
        check("rst_remainder", 64'(bus.remainder), 64'd0);
        check("rst_dbz",       64'(bus.div_by_zero), 64'd0);
        check("rst_ovf",       64'(bus.overflow), 64'd0);
`ifdef DIV_DONE_PULSE_EN
        check("rst_done",      64'(bus.done), 64'd0);
`endif

        run_op(64'd100, 32'd7, cyc);
        check_res("d100_7", cyc, 32, 32'd14, 32'd2, 1'b0, 1'b0);

        big = 64'd315111401 * 64'd318652716;
        run_op(big, 32'd318652716, cyc);
        check_res("exact", cyc, 32, 32'd315111401, 32'd0, 1'b0, 1'b0);

        run_op(big + 64'd7, 32'd318652716, cyc);
        check_res("exact_p7", cyc, 32, 32'd315111401, 32'd7, 1'b0, 1'b0);

        run_op(64'h0000_0001_2345_6789, 32'd0, cyc);
        check_res("dbz", cyc, 1, 32'hFFFF_FFFF, 32'h2345_6789, 1'b1, 1'b0);

        run_op(64'h1_0000_0000, 32'd1, cyc);
        check_res("ovf", cyc, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);

        run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check_res("maxdiv", cyc, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Start and operand changes at RUN cycle 5 must be ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            if (cyc == 5) begin
                bus.start    = 1'b1;
                bus.dividend = 64'd1000;
                bus.divisor  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check_res("ign_start", cyc, 32, 32'd14, 32'd2, 1'b0, 1'b0);
`ifdef DIV_DONE_PULSE_EN
        check("ign_done_hi", 64'(bus.done), 64'd1);
`endif
        @(negedge clk);
        check("ign_idle", 64'(bus.busy), 64'd0);

        // Reset at RUN cycle 10 discards the operation and clears outputs.
        bus.dividend = 64'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrun_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",      64'(bus.busy), 64'd0);
        check("midrst_quotient",  64'(bus.quotient), 64'd0);
        check("midrst_remainder", 64'(bus.remainder), 64'd0);
        check("midrst_dbz",       64'(bus.div_by_zero), 64'd0);
        check("midrst_ovf",       64'(bus.overflow), 64'd0);
`ifdef DIV_DONE_PULSE_EN
        check("midrst_done",      64'(bus.done), 64'd0);
`endif

        run_op(64'd100, 32'd7, cyc);
        check_res("after_rst", cyc, 32, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
